// File: rtl/apb_fir_stream_buffer.sv
// apb_fir_stream_buffer
//   APB slave that buffers CPU-written samples in an input FIFO, streams them
//   into the FIR core with a valid/ready handshake, and captures FIR results in
//   an output FIFO that the CPU pops over APB. Results arriving while the
//   output FIFO is full are discarded and counted in DROP_CNT.
//
//   Register map (PADDR[4:2]):
//     0x00 CTRL       rw  [0] EN, [1] FLUSH_IN (w1), [2] FLUSH_OUT (w1), [15:8] OUT_THRESH (irq build)
//     0x04 SAMPLE_IN  wo  push into input FIFO (PSLVERR when full)
//     0x08 RESULT_OUT ro  pop from output FIFO (PSLVERR and 0 when empty)
//     0x0C STATUS     ro  [7:0] in_level [15:8] out_level [16] in_full [17] in_empty
//                         [18] out_full [19] out_empty [20] irq
//     0x10 DROP_CNT   ro  saturating count of discarded results; any write clears
//     others              read 0xFFFFFFFF, writes ignored
//
//   Ports: HCLK/HRESETn (async active-low), APB slave (PADDR, PWDATA, PWRITE,
//   PSEL, PENABLE, PRDATA, PREADY, PSLVERR), FIR sample stream out (o_sample,
//   o_sample_valid, i_sample_ready), FIR result strobe in (i_result,
//   i_result_valid), and o_irq when built with FIR_BUF_IRQ_EN.
//
//   Build option FIR_BUF_IRQ_EN: adds o_irq and CTRL.OUT_THRESH; o_irq is a
//   registered level, high while out_level >= OUT_THRESH and OUT_THRESH != 0.
module apb_fir_stream_buffer #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int IN_DEPTH       = 8,
  parameter int OUT_DEPTH      = 8
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic [DATA_WIDTH-1:0]     o_sample,
  output logic                      o_sample_valid,
  input  logic                      i_sample_ready,
  input  logic [DATA_WIDTH-1:0]     i_result,
  input  logic                      i_result_valid
`ifdef FIR_BUF_IRQ_EN
  ,
  output logic                      o_irq
`endif
);

  localparam int IPW = $clog2(IN_DEPTH);
  localparam int ILW = $clog2(IN_DEPTH + 1);
  localparam int OPW = $clog2(OUT_DEPTH);
  localparam int OLW = $clog2(OUT_DEPTH + 1);
  localparam logic [ILW-1:0] IN_FULL_LVL  = ILW'(IN_DEPTH);
  localparam logic [OLW-1:0] OUT_FULL_LVL = OLW'(OUT_DEPTH);

  logic [DATA_WIDTH-1:0] in_mem_q  [IN_DEPTH];
  logic [DATA_WIDTH-1:0] out_mem_q [OUT_DEPTH];
  logic [IPW-1:0] in_wptr_q, in_rptr_q, in_wptr_d, in_rptr_d;
  logic [ILW-1:0] in_lvl_q, in_lvl_d;
  logic [OPW-1:0] out_wptr_q, out_rptr_q, out_wptr_d, out_rptr_d;
  logic [OLW-1:0] out_lvl_q, out_lvl_d;
  logic           en_q;
  logic [31:0]    drop_cnt_q, drop_cnt_d;
  logic [7:0]     thresh_q;
  logic           irq_q;

  logic       access, wr_en, rd_en;
  logic [2:0] reg_sel;
  logic       in_full, in_empty, out_full, out_empty;
  logic       push_req, push_ok, drain, flush_in, flush_out;
  logic       pop_req, pop_ok, cap_ok, drop;
  logic       unused_bits;

  assign access   = PSEL & PENABLE;
  assign wr_en    = access & PWRITE;
  assign rd_en    = access & ~PWRITE;
  assign reg_sel  = PADDR[4:2];

  assign in_full   = (in_lvl_q == IN_FULL_LVL);
  assign in_empty  = (in_lvl_q == '0);
  assign out_full  = (out_lvl_q == OUT_FULL_LVL);
  assign out_empty = (out_lvl_q == '0);

  assign o_sample_valid = en_q & ~in_empty;
  // Head is gated so the stream port reads 0 out of reset and after a flush.
  assign o_sample       = in_empty ? '0 : in_mem_q[in_rptr_q];

  assign drain     = o_sample_valid & i_sample_ready;
  assign push_req  = wr_en & (reg_sel == 3'd1);
  // A same-cycle drain frees the head slot, so a push into a full FIFO still lands.
  assign push_ok   = push_req & (~in_full | drain);
  assign flush_in  = wr_en & (reg_sel == 3'd0) & PWDATA[1];
  assign flush_out = wr_en & (reg_sel == 3'd0) & PWDATA[2];

  assign pop_req   = rd_en & (reg_sel == 3'd2);
  assign pop_ok    = pop_req & ~out_empty;
  assign cap_ok    = i_result_valid & (~out_full | pop_ok);
  assign drop      = i_result_valid & ~cap_ok;

  assign PREADY  = 1'b1;
  assign PSLVERR = (push_req & ~push_ok) | (pop_req & out_empty);

  assign unused_bits = ^{PADDR, PWDATA};

  always_comb begin
    in_wptr_d  = in_wptr_q;
    in_rptr_d  = in_rptr_q;
    in_lvl_d   = in_lvl_q;
    out_wptr_d = out_wptr_q;
    out_rptr_d = out_rptr_q;
    out_lvl_d  = out_lvl_q;
    drop_cnt_d = drop_cnt_q;

    if (flush_in) begin
      in_wptr_d = '0;
      in_rptr_d = '0;
      in_lvl_d  = '0;
    end else begin
      if (push_ok) in_wptr_d = in_wptr_q + IPW'(1);
      if (drain)   in_rptr_d = in_rptr_q + IPW'(1);
      if (push_ok && !drain)      in_lvl_d = in_lvl_q + ILW'(1);
      else if (!push_ok && drain) in_lvl_d = in_lvl_q - ILW'(1);
    end

    if (flush_out) begin
      out_wptr_d = '0;
      out_rptr_d = '0;
      out_lvl_d  = '0;
    end else begin
      if (cap_ok) out_wptr_d = out_wptr_q + OPW'(1);
      if (pop_ok) out_rptr_d = out_rptr_q + OPW'(1);
      if (cap_ok && !pop_ok)      out_lvl_d = out_lvl_q + OLW'(1);
      else if (!cap_ok && pop_ok) out_lvl_d = out_lvl_q - OLW'(1);
    end

    if (wr_en && reg_sel == 3'd4)  drop_cnt_d = '0;
    else if (drop && ~&drop_cnt_q) drop_cnt_d = drop_cnt_q + 32'd1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      in_wptr_q  <= '0;
      in_rptr_q  <= '0;
      in_lvl_q   <= '0;
      out_wptr_q <= '0;
      out_rptr_q <= '0;
      out_lvl_q  <= '0;
      drop_cnt_q <= '0;
      en_q       <= 1'b0;
    end else begin
      in_wptr_q  <= in_wptr_d;
      in_rptr_q  <= in_rptr_d;
      in_lvl_q   <= in_lvl_d;
      out_wptr_q <= out_wptr_d;
      out_rptr_q <= out_rptr_d;
      out_lvl_q  <= out_lvl_d;
      drop_cnt_q <= drop_cnt_d;
      if (wr_en && reg_sel == 3'd0) en_q <= PWDATA[0];
    end
  end

  // Storage needs no reset: occupancy is tracked by the level registers.
  always_ff @(posedge HCLK) begin
    if (push_ok && !flush_in)  in_mem_q[in_wptr_q]   <= PWDATA[DATA_WIDTH-1:0];
    if (cap_ok && !flush_out)  out_mem_q[out_wptr_q] <= i_result;
  end

`ifdef FIR_BUF_IRQ_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      thresh_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_en && reg_sel == 3'd0) thresh_q <= PWDATA[15:8];
      irq_q <= (thresh_q != 8'd0) && (8'(out_lvl_q) >= thresh_q);
    end
  end
  assign o_irq = irq_q;
`else
  assign thresh_q = '0;
  assign irq_q    = 1'b0;
`endif

  always_comb begin
    PRDATA = '0;
    case (reg_sel)
      3'd0: PRDATA = {16'd0, thresh_q, 7'd0, en_q};
      3'd1: PRDATA = '0;
      3'd2: PRDATA = out_empty ? '0 : 32'(out_mem_q[out_rptr_q]);
      3'd3: PRDATA = {11'd0, irq_q, out_empty, out_full, in_empty, in_full,
                      8'(out_lvl_q), 8'(in_lvl_q)};
      3'd4: PRDATA = drop_cnt_q;
      default: PRDATA = '1;
    endcase
  end

endmodule

// File: tb/tb_apb_fir_stream_buffer.sv
module tb_apb_fir_stream_buffer;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [11:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic        PWRITE = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] o_sample;
  logic        o_sample_valid;
  logic        i_sample_ready = 1'b0;
  logic [31:0] i_result = '0;
  logic        i_result_valid = 1'b0;
`ifdef FIR_BUF_IRQ_EN
  logic        o_irq;
`endif

  apb_fir_stream_buffer dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .o_sample(o_sample),
    .o_sample_valid(o_sample_valid), .i_sample_ready(i_sample_ready),
    .i_result(i_result), .i_result_valid(i_result_valid)
`ifdef FIR_BUF_IRQ_EN
    , .o_irq(o_irq)
`endif
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;
  logic [31:0] in_q[$];
  logic [31:0] out_q[$];
  logic [31:0] exp_drop = 0;
  logic        mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    int il = in_q.size();
    int ol = out_q.size();
    return {12'd0, (ol == 0), (ol == 8), (il == 0), (il == 8), 8'(ol), 8'(il)};
  endfunction

  // Stream scoreboard: every accepted sample must match the oldest pushed
  // value; a stalled head must hold steady.
  always @(negedge HCLK) begin
    if (mon_en && o_sample_valid) begin
      if (in_q.size() == 0) check("drain_extra", o_sample_valid, 0);
      else if (i_sample_ready) check("sample", o_sample, in_q.pop_front());
      else check("stall_hold", o_sample, in_q[0]);
    end
  end

  task automatic apb(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                     input logic cap, input logic [31:0] capv,
                     output logic [31:0] rdata, output logic err);
    @(posedge HCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge HCLK); #1;
    PENABLE = 1;
    if (cap) begin i_result = capv; i_result_valid = 1; end
    @(negedge HCLK);
    rdata = PRDATA; err = PSLVERR;
    @(posedge HCLK); #1;
    PSEL = 0; PENABLE = 0; PWRITE = 0; i_result_valid = 0;
  endtask

  task automatic wr_reg(input logic [11:0] addr, input logic [31:0] d);
    logic [31:0] r; logic e;
    apb(1, addr, d, 0, 0, r, e);
    check("wr_err", e, 0);
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    logic [31:0] r; logic e;
    apb(0, addr, 0, 0, 0, r, e);
    check(tag, r, exp);
  endtask

  task automatic push(input logic [31:0] d);
    logic [31:0] r; logic e; logic exp_err;
    exp_err = (in_q.size() >= 8);
    apb(1, 12'h004, d, 0, 0, r, e);
    check("push_err", e, exp_err);
    if (!exp_err) in_q.push_back(d);
  endtask

  task automatic pop(input logic cap, input logic [31:0] capv);
    logic [31:0] r; logic e; logic [31:0] exp_d; logic exp_err;
    exp_err = (out_q.size() == 0);
    exp_d = exp_err ? 32'd0 : out_q.pop_front();
    if (cap) begin
      if (out_q.size() < 8) out_q.push_back(capv);
      else exp_drop++;
    end
    apb(0, 12'h008, 0, cap, capv, r, e);
    check("pop_data", r, exp_d);
    check("pop_err", e, exp_err);
  endtask

  task automatic result(input logic [31:0] v);
    @(posedge HCLK); #1;
    i_result = v; i_result_valid = 1;
    if (out_q.size() < 8) out_q.push_back(v);
    else exp_drop++;
    @(posedge HCLK); #1;
    i_result_valid = 0;
  endtask

  task automatic wait_drained();
    for (int i = 0; i < 100 && in_q.size() != 0; i++) @(posedge HCLK);
    check("drain_timeout", in_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge HCLK);
    #1;
    check("rst_valid", o_sample_valid, 0);
    check("rst_sample", o_sample, 0);
    check("rst_pslverr", PSLVERR, 0);
    HRESETn = 1;
    mon_en = 1;
    check("pready", PREADY, 1);
    rd_chk("rst_status", 12'h00C, 32'h000A0000);
    rd_chk("rst_drop", 12'h010, 0);
    rd_chk("rst_ctrl", 12'h000, 0);

    // Streaming with FIR always ready
    i_sample_ready = 1;
    wr_reg(12'h000, 32'h1);
    push(32'h11); push(32'h22); push(32'h33);
    wait_drained();

    // Fill with EN=0, overflow, then stall and drain
    wr_reg(12'h000, 32'h0);
    for (int i = 0; i < 9; i++) push(32'hA0 + i);
    rd_chk("full_status", 12'h00C, exp_status());
    i_sample_ready = 0;
    wr_reg(12'h000, 32'h1);
    repeat (3) @(posedge HCLK);
    #1;
    check("stall_valid", o_sample_valid, 1);
    check("stall_first", o_sample, 32'hA0);
    i_sample_ready = 1;
    wait_drained();
    rd_chk("drained_status", 12'h00C, exp_status());

    // Input flush drops queued samples; flush bits read back as 0
    wr_reg(12'h000, 32'h0);
    push(32'h55); push(32'h66); push(32'h77);
    wr_reg(12'h000, 32'h2);
    in_q.delete();
    rd_chk("flush_status", 12'h00C, exp_status());
    rd_chk("flush_ctrl", 12'h000, 0);

    // Unmapped offsets
    rd_chk("bad_rd14", 12'h014, 32'hFFFFFFFF);
    rd_chk("bad_rd1c", 12'h01C, 32'hFFFFFFFF);
    wr_reg(12'h018, 32'h1);
    rd_chk("bad_wr_ctrl", 12'h000, 0);

    // Capture with overflow and drop counting
    for (int i = 0; i < 10; i++) result(32'h100 + i);
    rd_chk("drop_cnt", 12'h010, exp_drop);
    rd_chk("out_full_status", 12'h00C, exp_status());
    for (int i = 0; i < 9; i++) pop(0, 0);
    rd_chk("drop_keep", 12'h010, exp_drop);
    wr_reg(12'h010, 32'h0);
    exp_drop = 0;
    rd_chk("drop_clear", 12'h010, exp_drop);

    // Full output FIFO: pop and capture in the same cycle
    for (int i = 0; i < 8; i++) result(32'h200 + i);
    pop(1, 32'h2FF);
    rd_chk("popcap_status", 12'h00C, exp_status());
    rd_chk("popcap_drop", 12'h010, exp_drop);
    for (int i = 0; i < 8; i++) pop(0, 0);
    rd_chk("empty_status", 12'h00C, exp_status());

`ifdef FIR_BUF_IRQ_EN
    wr_reg(12'h000, 32'h300);
    result(32'h400); result(32'h401);
    @(posedge HCLK); #1;
    check("irq_below", o_irq, 0);
    result(32'h402);
    @(posedge HCLK); #1;
    check("irq_set", o_irq, 1);
    rd_chk("irq_ctrl", 12'h000, 32'h300);
    rd_chk("irq_status", 12'h00C, exp_status() | 32'h00100000);
    pop(0, 0);
    @(posedge HCLK); #1;
    check("irq_clear", o_irq, 0);
`endif

    // Asynchronous reset in the middle of a stalled stream
    i_sample_ready = 0;
    wr_reg(12'h000, 32'h0);
    push(32'h9A); push(32'h9B);
    result(32'h500); result(32'h501);
    wr_reg(12'h000, 32'h1);
    @(posedge HCLK); #1;
    check("pre_rst_valid", o_sample_valid, 1);
    @(posedge HCLK); #3;
    mon_en = 0;
    HRESETn = 0;
    #1;
    check("mid_rst_valid", o_sample_valid, 0);
    check("mid_rst_sample", o_sample, 0);
`ifdef FIR_BUF_IRQ_EN
    check("mid_rst_irq", o_irq, 0);
`endif
    in_q.delete(); out_q.delete(); exp_drop = 0;
    @(posedge HCLK); #1;
    HRESETn = 1;
    mon_en = 1;
    rd_chk("post_rst_status", 12'h00C, 32'h000A0000);
    rd_chk("post_rst_drop", 12'h010, 0);
    rd_chk("post_rst_ctrl", 12'h000, 0);
    pop(0, 0);

    repeat (2) @(posedge HCLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
